// File: rtl/bus_region_decoder.sv
// bus_region_decoder: 8088 bus front end with an edge-registered address latch,
// region chip selects, per-region wait states on READY and a decode-miss pulse.
module bus_region_decoder #(
    parameter int          N_REGIONS                 = 4,
    parameter int          WAIT_W                    = 4,
    parameter logic [19:0] REGION_LSB   [N_REGIONS]  = '{default: 20'h00000},
    parameter logic [19:0] REGION_MSB   [N_REGIONS]  = '{default: 20'hFFFFF},
    parameter logic        REGION_IS_IO [N_REGIONS]  = '{default: 1'b0},
    parameter int          REGION_WAIT  [N_REGIONS]  = '{default: 0}
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 ALE,
    input  logic [11:0]          A,
    input  logic [7:0]           AD,
    input  logic                 IOM,
    input  logic                 RD_N,
    input  logic                 WR_N,
    output logic [19:0]          ADDR,
    output logic [N_REGIONS-1:0] CS,
    output logic [3:0]           HIT_IDX,
    output logic                 READY,
    output logic                 DEC_ERR
);
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;

    state_t               state;
    logic [WAIT_W-1:0]    cnt;
    logic                 iom_q;
    logic                 strb;
    logic [N_REGIONS-1:0] hit_vec;
    logic [N_REGIONS-1:0] cs_d;
    logic [3:0]           hit_d;
    logic [WAIT_W-1:0]    wait_tab [16];

    if (N_REGIONS < 1 || N_REGIONS > 16) begin : g_bad_n
        $error("N_REGIONS must be within 1..16");
    end

    // Table padded to 16 entries so HIT_IDX can index it directly.
    for (genvar g = 0; g < 16; g++) begin : g_wait
        if (g < N_REGIONS) begin : g_used
            if (REGION_WAIT[g] < 0 || REGION_WAIT[g] >= 2 ** WAIT_W) begin : g_bad_wait
                $error("REGION_WAIT does not fit in WAIT_W bits");
            end
            assign wait_tab[g] = WAIT_W'(REGION_WAIT[g]);
        end else begin : g_unused
            assign wait_tab[g] = '0;
        end
    end

    // I/O regions compare only the 16-bit port number.
    for (genvar g = 0; g < N_REGIONS; g++) begin : g_reg
        assign hit_vec[g] = (REGION_IS_IO[g] == iom_q) &&
                            (iom_q ? (ADDR[15:0] >= REGION_LSB[g][15:0] && ADDR[15:0] <= REGION_MSB[g][15:0])
                                   : (ADDR >= REGION_LSB[g] && ADDR <= REGION_MSB[g]));
    end

    always_comb begin
        cs_d  = '0;
        hit_d = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                cs_d    = '0;
                cs_d[i] = 1'b1;
                hit_d   = 4'(i);
            end
        end
    end

    assign strb = ~RD_N | ~WR_N;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ADDR    <= '0;
            iom_q   <= 1'b0;
            CS      <= '0;
            HIT_IDX <= '0;
            READY   <= 1'b1;
            DEC_ERR <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
        end else begin
            DEC_ERR <= 1'b0;
            CS      <= cs_d;
            HIT_IDX <= hit_d;
            if (ALE) begin
                ADDR  <= {A, AD};
                iom_q <= IOM;
            end
            case (state)
                IDLE: begin
                    if (!ALE && strb) begin
                        if (CS == '0) begin
                            DEC_ERR <= 1'b1;
                            state   <= ACTIVE;
                        end else begin
                            cnt   <= wait_tab[HIT_IDX];
                            READY <= (wait_tab[HIT_IDX] == '0);
                            state <= (wait_tab[HIT_IDX] == '0) ? ACTIVE : WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= ALE ? '0 : cnt - 1'b1;
                    if (ALE || cnt == WAIT_W'(1)) begin
                        READY <= 1'b1;
                        state <= ALE ? IDLE : ACTIVE;
                    end
                end
                ACTIVE: state <= (ALE || !strb) ? IDLE : ACTIVE;
                default: begin
                    state <= IDLE;
                    READY <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_region_decoder.sv
// tb_bus_region_decoder: directed bench with a transaction-level model of the
// region map and bus handshake, compared against the DUT every cycle.
module tb_bus_region_decoder;
    localparam int          NR = 5;
    localparam logic [19:0] LSB [NR] = '{20'h00000, 20'h80000, 20'h00000, 20'h0FF00, 20'h02000};
    localparam logic [19:0] MSB [NR] = '{20'h7FFFF, 20'hFFFFF, 20'h000FF, 20'h0FF0F, 20'h020FF};
    localparam logic        RIO [NR] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam int          RW  [NR] = '{0, 2, 3, 1, 5};

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          ALE = 1'b0;
    logic [11:0]   A = '0;
    logic [7:0]    AD = '0;
    logic          IOM = 1'b0;
    logic          RD_N = 1'b1;
    logic          WR_N = 1'b1;
    logic [19:0]   ADDR;
    logic [NR-1:0] CS;
    logic [3:0]    HIT_IDX;
    logic          READY;
    logic          DEC_ERR;

    int checks = 0;
    int errors = 0;

    logic [19:0]   m_addr = '0;
    logic          m_iom = 1'b0;
    logic [NR-1:0] m_cs = '0;
    logic [3:0]    m_hit = '0;
    logic          m_ready = 1'b1;
    logic          m_err = 1'b0;
    int            phase = 0;
    int            left = 0;

    bus_region_decoder #(
        .N_REGIONS(NR), .WAIT_W(4),
        .REGION_LSB(LSB), .REGION_MSB(MSB), .REGION_IS_IO(RIO), .REGION_WAIT(RW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ALE(ALE), .A(A), .AD(AD), .IOM(IOM),
        .RD_N(RD_N), .WR_N(WR_N), .ADDR(ADDR), .CS(CS), .HIT_IDX(HIT_IDX),
        .READY(READY), .DEC_ERR(DEC_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic int region_of(input logic [19:0] addr, input logic io);
        for (int i = 0; i < NR; i++) begin
            logic [19:0] lo = LSB[i];
            logic [19:0] hi = MSB[i];
            int key = io ? int'(addr[15:0]) : int'(addr);
            int l = io ? int'(lo[15:0]) : int'(lo);
            int h = io ? int'(hi[15:0]) : int'(hi);
            if (RIO[i] == io && key >= l && key <= h) return i;
        end
        return -1;
    endfunction

    // Phase 0 = idle, 1 = waiting with `left` wait cycles still owed, 2 = strobe active.
    initial begin
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) begin
                m_addr = '0; m_iom = 1'b0; m_cs = '0; m_hit = '0;
                m_ready = 1'b1; m_err = 1'b0; phase = 0; left = 0;
            end else begin
                int r;
                logic s;
                s = !RD_N || !WR_N;
                m_err = 1'b0;
                if (phase == 0) begin
                    if (!ALE && s) begin
                        if (m_cs == '0) begin
                            m_err = 1'b1;
                            phase = 2;
                        end else if (RW[m_hit] > 0) begin
                            left = RW[m_hit];
                            m_ready = 1'b0;
                            phase = 1;
                        end else phase = 2;
                    end
                end else if (ALE) begin
                    phase = 0; m_ready = 1'b1; left = 0;
                end else if (phase == 1) begin
                    left--;
                    if (left == 0) begin
                        m_ready = 1'b1;
                        phase = 2;
                    end
                end else if (!s) phase = 0;
                r = region_of(m_addr, m_iom);
                m_cs = (r < 0) ? '0 : NR'(1 << r);
                m_hit = (r < 0) ? 4'd0 : 4'(r);
                if (ALE) begin
                    m_addr = {A, AD};
                    m_iom = IOM;
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("ADDR", 32'(ADDR), 32'(m_addr));
        chk("CS", 32'(CS), 32'(m_cs));
        if (m_cs != '0) chk("HIT_IDX", 32'(HIT_IDX), 32'(m_hit));
        chk("READY", 32'(READY), 32'(m_ready));
        chk("DEC_ERR", 32'(DEC_ERR), 32'(m_err));
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
            compare_all();
        end
    endtask

    task automatic latch(input logic [19:0] a, input logic io);
        ALE = 1'b1; A = a[19:8]; AD = a[7:0]; IOM = io;
        cyc();
        ALE = 1'b0;
        cyc();
    endtask

    // sel: 0 = read, 1 = write, 2 = both strobes at once
    task automatic access(input string n, input logic [19:0] a, input logic io, input int sel,
                          input logic [NR-1:0] exp_cs, input int exp_low, input int exp_err);
        int lows = 0;
        int errs = 0;
        latch(a, io);
        chk({n, "_cs"}, 32'(CS), 32'(exp_cs));
        if (exp_cs != '0) chk({n, "_hit"}, 32'(HIT_IDX), 32'($clog2(exp_cs)));
        RD_N = (sel == 1);
        WR_N = (sel == 0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            lows += int'(!READY);
            errs += int'(DEC_ERR);
        end
        RD_N = 1'b1; WR_N = 1'b1;
        cyc(2);
        chk({n, "_ready_low"}, 32'(lows), 32'(exp_low));
        chk({n, "_dec_err"}, 32'(errs), 32'(exp_err));
        chk({n, "_cs_hold"}, 32'(CS), 32'(exp_cs));
    endtask

    initial begin
        cyc(2);
        chk("rst_ready", 32'(READY), 32'd1);
        chk("rst_cs", 32'(CS), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        RESET_N = 1'b1;
        cyc(2);

        access("mem_hi", 20'h81234, 1'b0, 0, 5'b00010, 2, 0);
        chk("mem_hi_addr", 32'(ADDR), 32'h81234);
        chk("model_cs_pin", 32'(m_cs), 32'b00010);
        access("io_win", 20'h3FF05, 1'b1, 0, 5'b01000, 1, 0);
        access("io_as_mem", 20'h3FF05, 1'b0, 0, 5'b00001, 0, 0);
        access("io_miss", 20'h00100, 1'b1, 1, 5'b00000, 0, 1);
        chk("model_miss_pin", 32'(m_cs), 32'd0);
        access("overlap", 20'h00010, 1'b0, 0, 5'b00001, 0, 0);
        chk("model_overlap_pin", 32'(m_hit), 32'd0);
        access("mem_top_r0", 20'h7FFFF, 1'b0, 0, 5'b00001, 0, 0);
        access("mem_bot_r1", 20'h80000, 1'b0, 2, 5'b00010, 2, 0);
        access("io_top", 20'hFFF0F, 1'b1, 1, 5'b01000, 1, 0);
        access("io_past_top", 20'h0FF10, 1'b1, 0, 5'b00000, 0, 1);
        access("io_w5", 20'h02010, 1'b1, 2, 5'b10000, 5, 0);

        latch(20'h02010, 1'b1);
        RD_N = 1'b0;
        cyc(2);
        chk("abort_pre_ready", 32'(READY), 32'd0);
        ALE = 1'b1; A = 12'h812; AD = 8'h34; IOM = 1'b0;
        cyc();
        chk("abort_ready", 32'(READY), 32'd1);
        chk("abort_addr", 32'(ADDR), 32'h81234);
        ALE = 1'b0; RD_N = 1'b1;
        cyc(3);
        chk("abort_cs", 32'(CS), 32'b00010);

        latch(20'h02020, 1'b1);
        RD_N = 1'b0;
        cyc(2);
        chk("rst_pre_ready", 32'(READY), 32'd0);
        #2 RESET_N = 1'b0;
        #1;
        chk("rst_async_ready", 32'(READY), 32'd1);
        chk("rst_async_cs", 32'(CS), 32'd0);
        chk("rst_async_addr", 32'(ADDR), 32'd0);
        chk("rst_async_err", 32'(DEC_ERR), 32'd0);
        RD_N = 1'b1;
        cyc(2);
        RESET_N = 1'b1;
        cyc(2);
        access("post_rst", 20'h81234, 1'b0, 0, 5'b00010, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
